// File: rtl/mask_stream_gen.sv
// Synthetic pixel-stream source: de/hsync/vsync timing plus a solid rectangle in
// the mask plane, with rectangle geometry shadowed at each frame start.
module mask_stream_gen #(
    parameter int IMG_W   = 720,
    parameter int IMG_H   = 576,
    parameter int H_BLANK = 144,
    parameter int V_BLANK = 49
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        run,
    input  logic [9:0]  rect_x,
    input  logic [9:0]  rect_y,
    input  logic [9:0]  rect_w,
    input  logic [9:0]  rect_h,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        mask,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] W11    = 11'(IMG_W);
    localparam logic [10:0] H11    = 11'(IMG_H);
    localparam logic [10:0] H_LAST = 11'(IMG_W + H_BLANK - 1);
    localparam logic [10:0] V_LAST = 11'(IMG_H + V_BLANK - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, VBLANK} state_t;

    state_t      state, state_next;
    logic [10:0] h, v, h_next, v_next;
    logic        load_shadow;
    logic [9:0]  sx, sy, sw, sh;
    logic [10:0] sx_end, sy_end;
    logic        de_c, hsync_c, vsync_c, mask_c, fs_c;

    // Counter/state advance; the frame boundary is the only place run and the
    // rectangle inputs are looked at.
    always_comb begin
        state_next  = state;
        h_next      = h;
        v_next      = v;
        load_shadow = 1'b0;
        if (state == IDLE || (state == VBLANK && h == H_LAST && v == V_LAST)) begin
            if (run) begin
                state_next  = ACTIVE;
                h_next      = '0;
                v_next      = '0;
                load_shadow = 1'b1;
            end else begin
                state_next = IDLE;
                h_next     = '0;
                v_next     = H11;
            end
        end else if (h == H_LAST) begin
            h_next = '0;
            v_next = v + 11'd1;
            if (v + 11'd1 == H11)
                state_next = VBLANK;
        end else begin
            h_next = h + 11'd1;
        end
    end

    // 11-bit end points so x+w cannot wrap; clipping falls out of de.
    assign sx_end = {1'b0, sx} + {1'b0, sw};
    assign sy_end = {1'b0, sy} + {1'b0, sh};

    always_comb begin
        de_c    = (state == ACTIVE) && (h < W11);
        hsync_c = (state != IDLE) && (h < W11);
        vsync_c = (state == ACTIVE);
        mask_c  = de_c && (h >= {1'b0, sx}) && (h < sx_end)
                       && (v >= {1'b0, sy}) && (v < sy_end);
        fs_c    = (state == ACTIVE) && (h == 11'd0) && (v == 11'd0);
    end

    // Everything, outputs included, moves only on ce; reset wins over ce.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            h           <= '0;
            v           <= H11;
            sx          <= '0;
            sy          <= '0;
            sw          <= '0;
            sh          <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            mask        <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (ce) begin
            state       <= state_next;
            h           <= h_next;
            v           <= v_next;
            de          <= de_c;
            hsync       <= hsync_c;
            vsync       <= vsync_c;
            mask        <= mask_c;
            frame_start <= fs_c;
            if (load_shadow) begin
                sx <= rect_x;
                sy <= rect_y;
                sw <= rect_w;
                sh <= rect_h;
            end
            if (vsync && !vsync_c)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mask_stream_gen.sv
// Directed bench for mask_stream_gen with an 8x4 image, 4 h-blank, 2 v-blank
// (12x6 = 72 cycles per frame at ce=1).
module tb_mask_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        run;
    logic [9:0]  rect_x, rect_y, rect_w, rect_h;
    logic        de, hsync, vsync, mask, frame_start;
    logic [15:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;

    int idx, de_n, hs_n, vs_n, mask_n, fs_rises, fs_idx, fall_idx, cnt_before, cnt_at_fall;
    logic prev_fs = 1'b0, prev_vs = 1'b0;
    int   prev_fc = 0;

    mask_stream_gen #(.IMG_W(8), .IMG_H(4), .H_BLANK(4), .V_BLANK(2)) dut (
        .clk(clk), .rst(rst), .ce(ce), .run(run),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic reset_counts();
        idx = 0; de_n = 0; hs_n = 0; vs_n = 0; mask_n = 0;
        fs_rises = 0; fs_idx = 0; fall_idx = 0; cnt_before = -1; cnt_at_fall = -1;
    endtask

    task automatic set_rect(input int x, input int y, input int w, input int hh);
        rect_x = 10'(x); rect_y = 10'(y); rect_w = 10'(w); rect_h = 10'(hh);
    endtask

    // Advance n clocks, sampling 1 ns after each rising edge; optionally toggle ce.
    task automatic apply_stimulus(input int n, input bit toggle_ce);
        for (int i = 0; i < n; i++) begin
            if (toggle_ce) ce = ~ce;
            @(posedge clk);
            #1;
            idx++;
            de_n   += int'(de);
            hs_n   += int'(hsync);
            vs_n   += int'(vsync);
            mask_n += int'(mask);
            if (frame_start && !prev_fs) begin
                fs_rises++;
                if (fs_idx == 0) fs_idx = idx;
            end
            if (prev_vs && !vsync && fall_idx == 0) begin
                fall_idx    = idx;
                cnt_before  = prev_fc;
                cnt_at_fall = int'(frame_cnt);
            end
            prev_fs = frame_start;
            prev_vs = vsync;
            prev_fc = int'(frame_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1; run = 1'b1;
        set_rect(2, 1, 3, 2);
        reset_counts();
        apply_stimulus(3, 1'b0);
        check_output("reset_de", int'(de), 0);
        check_output("reset_hsync", int'(hsync), 0);
        check_output("reset_vsync", int'(vsync), 0);
        check_output("reset_mask", int'(mask), 0);
        check_output("reset_fs", int'(frame_start), 0);
        check_output("reset_frame_cnt", int'(frame_cnt), 0);

        // Release: the first edge only leaves IDLE, pixels start on the next.
        rst = 1'b1;
        apply_stimulus(1, 1'b0);
        check_output("release_de", int'(de), 0);
        check_output("release_vsync", int'(vsync), 0);

        // Frame 1 with rect (2,1,3,2); change rect halfway, must not tear.
        reset_counts();
        apply_stimulus(36, 1'b0);
        set_rect(0, 0, 8, 4);
        apply_stimulus(36, 1'b0);
        check_output("f1_de", de_n, 32);
        check_output("f1_hsync", hs_n, 48);
        check_output("f1_vsync", vs_n, 48);
        check_output("f1_mask", mask_n, 6);
        check_output("f1_fs_rises", fs_rises, 1);
        check_output("f1_fs_idx", fs_idx, 1);
        check_output("f1_vsync_fall_idx", fall_idx, 49);
        check_output("f1_cnt_before_fall", cnt_before, 0);
        check_output("f1_cnt_at_fall", cnt_at_fall, 1);
        check_output("f1_frame_cnt", int'(frame_cnt), 1);

        // Frame 2 full-image rect; queue a clipped rect for frame 3.
        reset_counts();
        apply_stimulus(36, 1'b0);
        set_rect(6, 3, 5, 5);
        apply_stimulus(36, 1'b0);
        check_output("f2_mask_full", mask_n, 32);
        check_output("f2_fs_idx", fs_idx, 1);
        check_output("f2_frame_cnt", int'(frame_cnt), 2);

        // Frame 3 clipped; queue zero width for frame 4.
        reset_counts();
        apply_stimulus(36, 1'b0);
        set_rect(2, 1, 0, 2);
        apply_stimulus(36, 1'b0);
        check_output("f3_mask_clipped", mask_n, 2);

        // Frame 4 zero width; drop run mid-frame, frame still completes.
        reset_counts();
        apply_stimulus(36, 1'b0);
        run = 1'b0;
        set_rect(2, 1, 3, 2);
        apply_stimulus(36, 1'b0);
        check_output("f4_mask_zero_w", mask_n, 0);
        check_output("f4_de_after_run_drop", de_n, 32);
        check_output("f4_frame_cnt", int'(frame_cnt), 4);

        reset_counts();
        apply_stimulus(10, 1'b0);
        check_output("idle_de", de_n, 0);
        check_output("idle_vsync", vs_n, 0);
        check_output("idle_hsync", hs_n, 0);
        check_output("idle_fs", fs_rises, 0);
        check_output("idle_frame_cnt", int'(frame_cnt), 4);

        // Reassert run: one transition edge, then frame 5 from v=0.
        run = 1'b1;
        apply_stimulus(1, 1'b0);
        check_output("rerun_de_latency", int'(de), 0);
        reset_counts();
        apply_stimulus(72, 1'b0);
        check_output("f5_fs_idx", fs_idx, 1);
        check_output("f5_mask", mask_n, 6);
        check_output("f5_de", de_n, 32);
        check_output("f5_frame_cnt", int'(frame_cnt), 5);

        // Frame 6 with ce toggling: every waveform doubled in length.
        reset_counts();
        apply_stimulus(144, 1'b1);
        check_output("f6_ce_de", de_n, 64);
        check_output("f6_ce_vsync", vs_n, 96);
        check_output("f6_ce_mask", mask_n, 12);
        check_output("f6_ce_fs_rises", fs_rises, 1);
        check_output("f6_frame_cnt", int'(frame_cnt), 6);

        // Into line 2 of frame 7, then synchronous reset aborts the frame.
        ce = 1'b1;
        reset_counts();
        apply_stimulus(30, 1'b0);
        check_output("f7_line2_vsync", int'(vsync), 1);
        check_output("f7_line2_hsync", int'(hsync), 1);
        rst = 1'b0;
        apply_stimulus(1, 1'b0);
        check_output("abort_de", int'(de), 0);
        check_output("abort_hsync", int'(hsync), 0);
        check_output("abort_vsync", int'(vsync), 0);
        check_output("abort_mask", int'(mask), 0);
        check_output("abort_fs", int'(frame_start), 0);
        check_output("abort_frame_cnt", int'(frame_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mask_stream_gen.md
Name: mask_stream_gen

Overview:
- Synthetic video source: produces the de/hsync/vsync/mask pixel stream that the skin-segmentation back end (centroid, summators) consumes.
- Draws a programmable solid rectangle in the mask plane, so the centroid path can be exercised on-chip and in simulation against known answers.
- Drop-in for the camera/segmentation front end; transmitter side of the same pixel-stream interface.

Parameters:
- IMG_W, 720, active pixels per line
- IMG_H, 576, active lines per frame
- H_BLANK, 144, blank pixels per line
- V_BLANK, 49, blank lines per frame
- Constraint: IMG_W+H_BLANK ≤ 2047 and IMG_H+V_BLANK ≤ 2047. All four must be ≥1.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge)
- ce  in  1  pixel enable; state advances only when ce=1
- run  in  1  start/continue frames; sampled at frame boundary
- rect_x  in  10  rectangle left column
- rect_y  in  10  rectangle top line
- rect_w  in  10  rectangle width in pixels (0 = no rectangle)
- rect_h  in  10  rectangle height in lines (0 = no rectangle)
- de  out  1  active pixel
- hsync  out  1  1 outside horizontal blank, 0 during horizontal blank
- vsync  out  1  1 during active lines, 0 during vertical blank/idle
- mask  out  1  1 when de=1 and the pixel lies inside the shadowed rectangle
- frame_start  out  1  one-cycle pulse with the first active pixel of each frame
- frame_cnt  out  16  completed frames, wraps at 65535→0

Behaviour:
- Counters: h, 11 bits, range 0..IMG_W+H_BLANK-1; v, 11 bits, range 0..IMG_H+V_BLANK-1. h wraps to 0 and increments v; v wraps to 0 at the end of its last line.
- Active region: h<IMG_W and v<IMG_H.
- State machine:
  - IDLE: counters held at h=0, v=IMG_H. All outputs 0.
  - ACTIVE: v<IMG_H.
  - VBLANK: v≥IMG_H.
- Frame boundary is the cycle where h and v are both at their last values (VBLANK→next frame), or any ce cycle in IDLE.
  - At the boundary with run=1: go to ACTIVE with h=0, v=0, and load the shadow regs from rect_* inputs.
  - At the boundary with run=0: go to IDLE.
  - run changes mid-frame have no effect until the boundary.
- Shadow registers: rectangle inputs are used only through shadows loaded at frame start, so mid-frame input changes never tear a frame.
- Mask: 1 iff de, sx ≤ h < sx+sw, and sy ≤ v < sy+sh.
  - Compare at 11 bits so that sx+sw never overflows.
  - Implicit clipping at IMG_W/IMG_H.
  - sw=0 or sh=0 gives mask=0 for the whole frame.
  - A rectangle starting beyond the image gives mask=0.
- Outputs are registered and reflect the h/v of the previous ce cycle (1-cycle latency). All outputs change only on ce=1 cycles.
  - de = active.
  - hsync = (h<IMG_W).
  - vsync = (v<IMG_H) in ACTIVE, 0 otherwise.
- frame_start: 1 with the de of h=0, v=0.
- frame_cnt: increments on the cycle vsync falls (end of the last active line), i.e. coincident with the downstream eof.
- Reset (rst=0): state IDLE, h=0, v=IMG_H, shadows=0, frame_cnt=0, and de/hsync/vsync/mask/frame_start=0.
  - Reset mid-frame aborts immediately, with vsync going low at the next edge.
  - The first frame after reset release needs run=1 and ce=1, and starts one cycle later.
- ce=0: nothing changes, including frame_start (it pulses exactly once per frame regardless of ce gaps).

Test Plan:
- Sim params IMG_W=8, IMG_H=4, H_BLANK=4, V_BLANK=2. Release rst with run=1, ce=1 → vsync high for 4×12=48 cycles then low for 24; de high 8 of every 12 cycles; frame_start pulses every 72 cycles; frame_cnt 0→1 at the first vsync fall.
- rect=(2,1,3,2) → mask high at h=2..4 on lines v=1..2, 6 mask pixels per frame; centroid block downstream latches x=3, y=1.
- rect=(6,3,5,5) → clipped: mask only at h=6..7, v=3, giving 2 pixels. rect_w=0 → no mask pixels.
- Change rect from (2,1,3,2) to (0,0,8,4) mid-frame → the current frame still shows 6 pixels; the next frame shows 32.
- Drop run mid-frame → the frame completes and the block goes IDLE with vsync=0 and frame_cnt +1. Reassert run → the next frame starts at v=0 with a frame_start pulse.
- Toggle ce 1/0 every cycle → every waveform is stretched exactly 2×, with identical mask count. Assert rst=0 during line 2 → all outputs 0 at the next edge and frame_cnt=0.
